fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one data beat; SHALL match the FIFO wr_din width.
REQ-002 Parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port; legal range 2..8.
REQ-003 Parameter BURST_LEN, default 4: maximum beats per grant; legal range 1..DEPTH.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  block clock; SHALL be the same clock as the FIFO write clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 arb_en  input  1  1 = new grants allowed; 0 = an in-flight burst completes, then no new grant is issued.
REQ-008 req_vld  input  NUM_REQ  per-requester beat valid; bit i belongs to requester i.
REQ-009 req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 req_rdy  output  NUM_REQ  per-requester beat accepted this cycle.
REQ-011 grant  output  NUM_REQ  registered one-hot owner of the write port; all zero when idle.
REQ-012 fifo_wr_en  output  1  FIFO write enable.
REQ-013 fifo_wr_din  output  DATA_WIDTH  FIFO write data.
REQ-014 fifo_full  input  1  FIFO full flag (registered, wr_clk domain).
REQ-015 fifo_al_full  input  1  FIFO almost-full flag (registered, wr_clk domain).
REQ-016 busy  output  1  1 while in GRANT state.

Function
REQ-017 The FSM SHALL have two states, IDLE and GRANT; grant is nonzero only in GRANT.
REQ-018 IDLE -> GRANT at a clock edge when arb_en=1, |req_vld=1 and fifo_al_full=0; otherwise the FSM stays in IDLE.
REQ-019 The winner SHALL be the first requester with req_vld=1, searching upward from rr_ptr with wrap from NUM_REQ-1 to 0; grant gets that one-hot value at the transition edge.
REQ-020 A beat SHALL transfer in any cycle where grant[g]=1, req_vld[g]=1 and fifo_full=0.
REQ-021 fifo_wr_en SHALL be driven combinationally as (|(grant & req_vld)) & ~fifo_full.
REQ-022 req_rdy SHALL equal grant & req_vld with every bit forced to 0 when fifo_full=1.
REQ-023 fifo_wr_din SHALL be the req_data slice of the granted requester, and 0 when grant=0.
REQ-024 beat_cnt (width clog2(BURST_LEN)+1) SHALL clear on entry to GRANT and increment by 1 per transferred beat.
REQ-025 GRANT -> IDLE at the edge where either the BURST_LEN-th beat transfers, or req_vld[g]=0 (early end; no beat transfers).
REQ-026 On every GRANT -> IDLE transition, rr_ptr SHALL become (g+1) mod NUM_REQ; grant clears at the same edge.
REQ-027 At least one IDLE cycle SHALL separate consecutive bursts, including bursts to the same requester.
REQ-028 fifo_full=1 during GRANT stalls the burst: no transfer, beat_cnt and grant held, no timeout.
REQ-029 fifo_al_full affects only the IDLE -> GRANT decision; it never ends a burst already in progress.
REQ-030 arb_en falling during GRANT SHALL NOT abort the burst.
REQ-031 req_vld on a non-granted requester SHALL be ignored; its req_rdy stays 0.

Reset
REQ-032 While rst_n=0, the following SHALL hold: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, busy=0, fifo_wr_en=0, req_rdy=0, fifo_wr_din=0.
REQ-033 Reset asserted mid-burst SHALL abort the burst immediately; partial beats already written stay in the FIFO.
REQ-034 The first grant after reset release SHALL go to the lowest-indexed valid requester.

Verification
REQ-035 Stimulus: after reset, req_vld=4'b1010 held with continuous data, arb_en=1, FIFO empty. Required response: grant 4'b0010 for 4 beats, then 1 IDLE cycle, then grant 4'b1000 for 4 beats, then grant 4'b0010 again.
REQ-036 Stimulus: requester 0 drops req_vld after 2 beats. Required response: exactly 2 writes, grant clears at the next edge, rr_ptr=1.
REQ-037 Stimulus: fifo_full=1 for 3 cycles mid-burst at beat 2. Required response: fifo_wr_en=0 and req_rdy=0 for those 3 cycles; beats 3-4 follow afterward; total 4 writes with no data loss or duplication.
REQ-038 Stimulus: fifo_al_full=1 in IDLE with req_vld=4'b1111. Required response: no grant until fifo_al_full=0. Stimulus: fifo_al_full rises mid-burst. Required response: the burst continues.
REQ-039 Stimulus: rst_n pulsed low during beat 3 of a burst by requester 2. Required response: all outputs 0 immediately; the next grant goes to requester 0 if it is valid.
REQ-040 Stimulus: arb_en=0 during an active burst. Required response: the burst completes; no further grant occurs while arb_en stays 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ requesters.
// Each grant covers a burst of up to BURST_LEN beats, and at least one idle cycle separates consecutive bursts.
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_arb_en,
  input  logic [NUM_REQ-1:0]            i_req_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_rdy,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_wr_din,
  input  logic                          i_fifo_full,
  input  logic                          i_fifo_al_full,
  output logic                          o_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   w_grant_nxt;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     w_rr_ptr_nxt;
  logic [PTR_W-1:0]     r_gidx;
  logic [PTR_W-1:0]     w_gidx_nxt;
  logic [PTR_W-1:0]     w_gidx_inc;
  logic [PTR_W-1:0]     w_win_idx;
  logic                 w_win_found;
  logic [CNT_W-1:0]     r_beat_cnt;
  logic [CNT_W-1:0]     w_beat_cnt_nxt;
  logic [NUM_REQ-1:0]   w_req_act;
  logic                 w_owner_vld;
  logic                 w_xfer;

  assign w_req_act    = r_grant & i_req_vld;
  assign w_owner_vld  = |w_req_act;
  assign w_xfer       = w_owner_vld & ~i_fifo_full;
  assign w_gidx_inc   = (r_gidx == LAST_REQ) ? '0 : r_gidx + PTR_W'(1);

  assign o_grant      = r_grant;
  assign o_busy       = (r_state == GRANT);
  assign o_fifo_wr_en = w_xfer;
  assign o_req_rdy    = i_fifo_full ? '0 : w_req_act;

  // Scan downward so the smallest offset from r_rr_ptr is written last and wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_vld[PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ)]) begin
        w_win_found = 1'b1;
        w_win_idx   = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    o_fifo_wr_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        o_fifo_wr_din = o_fifo_wr_din | i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_gidx_nxt     = r_gidx;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (i_arb_en && w_win_found && !i_fifo_al_full) begin
          w_state_nxt    = GRANT;
          w_grant_nxt    = NUM_REQ'(1) << w_win_idx;
          w_gidx_nxt     = w_win_idx;
          w_beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
        // A stalled beat (fifo_full) keeps the burst alive; only a dropped valid or the last beat ends it.
        if (!w_owner_vld || (w_xfer && (r_beat_cnt == LAST_BEAT))) begin
          w_state_nxt  = IDLE;
          w_grant_nxt  = '0;
          w_rr_ptr_nxt = w_gidx_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_gidx     <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_gidx     <= w_gidx_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenario tasks plus a randomized run
// compared cycle by cycle against an ownership/beat-count reference model.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk;
  logic          rst_n;
  logic          arbEn;
  logic [N-1:0]  reqVld;
  logic [N*DW-1:0] reqData;
  logic [N-1:0]  reqRdy;
  logic [N-1:0]  grant;
  logic          fifoWrEn;
  logic [DW-1:0] fifoWrDin;
  logic          fifoFull;
  logic          fifoAlFull;
  logic          busy;

  int nChecks;
  int nPass;
  int mOwner;
  int mPtr;
  int mBeats;

  fifo_wr_arb #(.DATA_WIDTH(DW), .NUM_REQ(N), .BURST_LEN(BL)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_arb_en      (arbEn),
    .i_req_vld     (reqVld),
    .i_req_data    (reqData),
    .o_req_rdy     (reqRdy),
    .o_grant       (grant),
    .o_fifo_wr_en  (fifoWrEn),
    .o_fifo_wr_din (fifoWrDin),
    .i_fifo_full   (fifoFull),
    .i_fifo_al_full(fifoAlFull),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mOwner is the requester holding the port (-1 when idle).
  task automatic model_step();
    logic found;
    if (mOwner < 0) begin
      if (arbEn && (reqVld != '0) && !fifoAlFull) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (mPtr + k) % N;
          if (!found && reqVld[idx[1:0]]) begin
            found  = 1'b1;
            mOwner = idx;
          end
        end
        mBeats = 0;
      end
    end else if (!reqVld[mOwner[1:0]]) begin
      mPtr   = (mOwner + 1) % N;
      mOwner = -1;
    end else if (!fifoFull) begin
      mBeats++;
      if (mBeats == BL) begin
        mPtr   = (mOwner + 1) % N;
        mOwner = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    arbEn      = 1'b0;
    reqVld     = '0;
    reqData    = '0;
    fifoFull   = 1'b0;
    fifoAlFull = 1'b0;
    mOwner     = -1;
    mPtr       = 0;
    mBeats     = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    arbEn   = 1'b1;
    reqVld  = 4'b1111;
    reqData = $urandom;
    mOwner  = -1;
    mPtr    = 0;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (grant !== 4'b0000) $display("[TB] FAIL reset_grant: got %b want 0000", grant); else nPass++;
    nChecks++; if (fifoWrEn !== 1'b0) $display("[TB] FAIL reset_wr_en: got %b want 0", fifoWrEn); else nPass++;
    nChecks++; if (reqRdy !== 4'b0000) $display("[TB] FAIL reset_rdy: got %b want 0000", reqRdy); else nPass++;
    nChecks++; if (fifoWrDin !== 8'h00) $display("[TB] FAIL reset_din: got %h want 00", fifoWrDin); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else nPass++;
    rst_n  = 1'b1;
    reqVld = 4'b0110;
    @(negedge clk);
    nChecks++; if (grant !== 4'b0000) $display("[TB] FAIL first_idle: got %b want 0000", grant); else nPass++;
    tick();
    @(negedge clk);
    nChecks++; if (grant !== 4'b0010) $display("[TB] FAIL first_grant_lowest: got %b want 0010", grant); else nPass++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] rrExp [0:11];
    logic [7:0] dinExp;
    rrExp = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
              4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0010};
    do_reset();
    arbEn  = 1'b1;
    reqVld = 4'b1010;
    for (int c = 0; c < 12; c++) begin
      reqData = $urandom;
      @(negedge clk);
      nChecks++; if (grant !== rrExp[c]) $display("[TB] FAIL rr_grant c%0d: got %b want %b", c, grant, rrExp[c]); else nPass++;
      dinExp = (rrExp[c] == 4'b0010) ? reqData[15:8] : (rrExp[c] == 4'b1000) ? reqData[31:24] : 8'h00;
      nChecks++; if (fifoWrDin !== dinExp) $display("[TB] FAIL rr_din c%0d: got %h want %h", c, fifoWrDin, dinExp); else nPass++;
      tick();
    end
  endtask

  task automatic test_early_end();
    int writes;
    writes = 0;
    do_reset();
    arbEn  = 1'b1;
    reqVld = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      reqData = $urandom;
      @(negedge clk);
      if (fifoWrEn) writes++;
      tick();
    end
    reqVld = 4'b0000;
    @(negedge clk);
    if (fifoWrEn) writes++;
    nChecks++; if (grant !== 4'b0001) $display("[TB] FAIL early_grant_held: got %b want 0001", grant); else nPass++;
    tick();
    reqVld = 4'b1111;
    @(negedge clk);
    nChecks++; if (grant !== 4'b0000) $display("[TB] FAIL early_grant_clear: got %b want 0000", grant); else nPass++;
    nChecks++; if (writes !== 2) $display("[TB] FAIL early_writes: got %0d want 2", writes); else nPass++;
    tick();
    @(negedge clk);
    nChecks++; if (grant !== 4'b0010) $display("[TB] FAIL early_next_ptr: got %b want 0010", grant); else nPass++;
    tick();
  endtask

  task automatic test_full_stall();
    logic       fullPat [0:8];
    logic [7:0] dataPat [0:8];
    logic [7:0] got [$];
    fullPat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    dataPat = '{8'h10, 8'h10, 8'h11, 8'h12, 8'h12, 8'h12, 8'h12, 8'h13, 8'h13};
    got.delete();
    do_reset();
    arbEn  = 1'b1;
    reqVld = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      fifoFull       = fullPat[c];
      reqData[7:0]   = dataPat[c];
      @(negedge clk);
      if (fifoWrEn) got.push_back(fifoWrDin);
      if (fullPat[c]) begin
        nChecks++; if (fifoWrEn !== 1'b0) $display("[TB] FAIL stall_wr_en c%0d: got %b want 0", c, fifoWrEn); else nPass++;
        nChecks++; if (reqRdy !== 4'b0000) $display("[TB] FAIL stall_rdy c%0d: got %b want 0000", c, reqRdy); else nPass++;
        nChecks++; if (grant !== 4'b0001) $display("[TB] FAIL stall_grant c%0d: got %b want 0001", c, grant); else nPass++;
      end
      tick();
    end
    reqVld   = 4'b0000;
    fifoFull = 1'b0;
    nChecks++; if (got.size() !== 4) $display("[TB] FAIL stall_writes: got %0d want 4", got.size()); else nPass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      nChecks++; if (got[i] !== 8'(8'h10 + i)) $display("[TB] FAIL stall_data%0d: got %h want %h", i, got[i], 8'(8'h10 + i)); else nPass++;
    end
    tick();
  endtask

  task automatic test_al_full();
    int writes;
    writes = 0;
    do_reset();
    arbEn      = 1'b1;
    reqVld     = 4'b1111;
    fifoAlFull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nChecks++; if (grant !== 4'b0000) $display("[TB] FAIL alfull_block c%0d: got %b want 0000", c, grant); else nPass++;
      tick();
    end
    fifoAlFull = 1'b0;
    for (int c = 3; c < 9; c++) begin
      if (c >= 5) fifoAlFull = 1'b1;
      reqData = $urandom;
      @(negedge clk);
      if (fifoWrEn) writes++;
      if (c == 4 || c == 7) begin
        nChecks++; if (grant !== 4'b0001) $display("[TB] FAIL alfull_burst c%0d: got %b want 0001", c, grant); else nPass++;
      end
      if (c == 8) begin
        nChecks++; if (grant !== 4'b0000) $display("[TB] FAIL alfull_no_regrant: got %b want 0000", grant); else nPass++;
      end
      tick();
    end
    nChecks++; if (writes !== 4) $display("[TB] FAIL alfull_writes: got %0d want 4", writes); else nPass++;
    fifoAlFull = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    arbEn = 1'b1;
    for (int c = 0; c < 9; c++) begin
      reqVld  = (c < 5) ? 4'b0010 : 4'b0100;
      reqData = $urandom;
      @(negedge clk);
      if (c == 8) begin
        nChecks++; if (grant !== 4'b0100) $display("[TB] FAIL rstmid_pre: got %b want 0100", grant); else nPass++;
      end
      if (c < 8) tick();
    end
    #2 rst_n = 1'b0;
    mOwner = -1;
    mPtr   = 0;
    #1;
    nChecks++; if (grant !== 4'b0000) $display("[TB] FAIL rstmid_grant: got %b want 0000", grant); else nPass++;
    nChecks++; if (fifoWrEn !== 1'b0) $display("[TB] FAIL rstmid_wr_en: got %b want 0", fifoWrEn); else nPass++;
    nChecks++; if (reqRdy !== 4'b0000) $display("[TB] FAIL rstmid_rdy: got %b want 0000", reqRdy); else nPass++;
    nChecks++; if (fifoWrDin !== 8'h00) $display("[TB] FAIL rstmid_din: got %h want 00", fifoWrDin); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b want 0", busy); else nPass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    reqVld = 4'b0111;
    @(negedge clk);
    tick();
    @(negedge clk);
    nChecks++; if (grant !== 4'b0001) $display("[TB] FAIL rstmid_regrant: got %b want 0001", grant); else nPass++;
    tick();
  endtask

  task automatic test_arb_en();
    int writes;
    writes = 0;
    do_reset();
    arbEn  = 1'b1;
    reqVld = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) arbEn = 1'b0;
      reqData = $urandom;
      @(negedge clk);
      if (fifoWrEn) writes++;
      if (c >= 5) begin
        nChecks++; if (grant !== 4'b0000) $display("[TB] FAIL arben_no_grant c%0d: got %b want 0000", c, grant); else nPass++;
      end
      tick();
    end
    nChecks++; if (writes !== 4) $display("[TB] FAIL arben_writes: got %0d want 4", writes); else nPass++;
    arbEn = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    nChecks++; if (grant !== 4'b0010) $display("[TB] FAIL arben_resume: got %b want 0010", grant); else nPass++;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]  eGrant;
    logic [N-1:0]  eRdy;
    logic          eWrEn;
    logic [DW-1:0] eDin;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) reqVld[i] = ($urandom % 4) != 0;
      reqData    = $urandom;
      fifoFull   = ($urandom % 5) == 0;
      fifoAlFull = ($urandom % 4) == 0;
      arbEn      = ($urandom % 8) != 0;
      @(negedge clk);
      eGrant = '0;
      eRdy   = '0;
      eWrEn  = 1'b0;
      eDin   = '0;
      if (mOwner >= 0) begin
        eGrant[mOwner[1:0]] = 1'b1;
        eDin  = reqData[mOwner*DW +: DW];
        eWrEn = reqVld[mOwner[1:0]] && !fifoFull;
        if (eWrEn) eRdy[mOwner[1:0]] = 1'b1;
      end
      nChecks++; if (grant !== eGrant) $display("[TB] FAIL rnd_grant c%0d: got %b want %b", c, grant, eGrant); else nPass++;
      nChecks++; if (fifoWrEn !== eWrEn) $display("[TB] FAIL rnd_wr_en c%0d: got %b want %b", c, fifoWrEn, eWrEn); else nPass++;
      nChecks++; if (fifoWrDin !== eDin) $display("[TB] FAIL rnd_din c%0d: got %h want %h", c, fifoWrDin, eDin); else nPass++;
      nChecks++; if (reqRdy !== eRdy) $display("[TB] FAIL rnd_rdy c%0d: got %b want %b", c, reqRdy, eRdy); else nPass++;
      nChecks++; if (busy !== (mOwner >= 0)) $display("[TB] FAIL rnd_busy c%0d: got %b want %b", c, busy, (mOwner >= 0)); else nPass++;
      tick();
    end
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    rst_n   = 1'b0;
    arbEn   = 1'b0;
    reqVld  = '0;
    reqData = '0;
    fifoFull   = 1'b0;
    fifoAlFull = 1'b0;
    mOwner = -1;
    mPtr   = 0;
    mBeats = 0;
    #1;
    test_reset();
    test_round_robin();
    test_early_end();
    test_full_stall();
    test_al_full();
    test_reset_mid_burst();
    test_arb_en();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
